// File: rtl/condicionador_botoes.sv
// Button conditioner: sync, debounce and one-hot validation of four buttons; one jogada per press.
// Optional long-press pulse built only when BOTAO_LONGO_EN is defined.
module condicionador_botoes #(
  parameter int unsigned DEBOUNCE_CICLOS = 20,
  parameter int unsigned LONGO_CICLOS    = 2000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] botoes,
  output logic [3:0] jogada,
  output logic       tem_jogada,
  output logic       jogada_invalida,
  output logic       pressao_longa,
  output logic       botao_ativo,
  output logic [1:0] db_estado
);

  localparam int unsigned CW = $clog2(LONGO_CICLOS + 1);
  localparam logic [CW-1:0] DEB_FIM = CW'(DEBOUNCE_CICLOS - 1);

  typedef enum logic [1:0] {
    ESPERA   = 2'd0,
    FILTRA   = 2'd1,
    REGISTRA = 2'd2,
    SOLTA    = 2'd3
  } estado_t;

  estado_t       estado_q, estado_d;
  logic [3:0]    sync1_q;
  logic [3:0]    b_sync_q;
  logic [3:0]    amostra_q, amostra_d;
  logic [CW-1:0] cont_q, cont_d;
  logic [3:0]    jogada_q, jogada_d;
  logic          tem_q, tem_d;
  logic          inv_q, inv_d;
  logic          ativo_q, ativo_d;

  function automatic logic [CW-1:0] inc_sat(input logic [CW-1:0] v);
    return (v == '1) ? v : v + CW'(1);
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q  <= '0;
      b_sync_q <= '0;
    end else begin
      sync1_q  <= botoes;
      b_sync_q <= sync1_q;
    end
  end

  always_comb begin
    estado_d  = estado_q;
    amostra_d = amostra_q;
    cont_d    = cont_q;
    jogada_d  = jogada_q;
    tem_d     = 1'b0;
    inv_d     = 1'b0;
    case (estado_q)
      ESPERA: begin
        if (b_sync_q != '0) begin
          amostra_d = b_sync_q;
          cont_d    = '0;
          estado_d  = FILTRA;
        end
      end
      FILTRA: begin
        if (b_sync_q == '0) begin
          estado_d = ESPERA;
        end else if (b_sync_q != amostra_q) begin
          amostra_d = b_sync_q;
          cont_d    = '0;
        end else if (cont_q == DEB_FIM) begin
          estado_d = REGISTRA;
        end else begin
          cont_d = inc_sat(cont_q);
        end
      end
      REGISTRA: begin
        if ($onehot(amostra_q)) begin
          jogada_d = amostra_q;
          tem_d    = 1'b1;
        end else begin
          inv_d = 1'b1;
        end
        cont_d   = '0;
        estado_d = SOLTA;
      end
      SOLTA: begin
        // Any nonzero sample restarts the release window, absorbing release bounce.
        if (b_sync_q == '0) begin
          if (cont_q == DEB_FIM) estado_d = ESPERA;
          else                   cont_d   = inc_sat(cont_q);
        end else begin
          cont_d = '0;
        end
      end
      default: estado_d = ESPERA;
    endcase
    ativo_d = (estado_d != ESPERA);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q  <= ESPERA;
      amostra_q <= '0;
      cont_q    <= '0;
      jogada_q  <= '0;
      tem_q     <= 1'b0;
      inv_q     <= 1'b0;
      ativo_q   <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      amostra_q <= amostra_d;
      cont_q    <= cont_d;
      jogada_q  <= jogada_d;
      tem_q     <= tem_d;
      inv_q     <= inv_d;
      ativo_q   <= ativo_d;
    end
  end

`ifdef BOTAO_LONGO_EN
  localparam logic [CW-1:0] LONGO_FIM = CW'(LONGO_CICLOS - 1);

  logic [CW-1:0] longo_q, longo_d;
  logic          arma_q, arma_d;
  logic          longa_q, longa_d;

  // Armed only by a valid REGISTRA; any deviation disarms for the rest of the press.
  always_comb begin
    longo_d = longo_q;
    arma_d  = arma_q;
    longa_d = 1'b0;
    if (estado_q == REGISTRA) begin
      arma_d  = $onehot(amostra_q);
      longo_d = '0;
    end else if (estado_q == SOLTA && arma_q) begin
      if (b_sync_q != amostra_q) begin
        arma_d = 1'b0;
      end else if (longo_q == LONGO_FIM) begin
        longa_d = 1'b1;
        arma_d  = 1'b0;
      end else begin
        longo_d = inc_sat(longo_q);
      end
    end else begin
      arma_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      longo_q <= '0;
      arma_q  <= 1'b0;
      longa_q <= 1'b0;
    end else begin
      longo_q <= longo_d;
      arma_q  <= arma_d;
      longa_q <= longa_d;
    end
  end

  assign pressao_longa = longa_q;
`else
  assign pressao_longa = 1'b0;
`endif

  assign jogada          = jogada_q;
  assign tem_jogada      = tem_q;
  assign jogada_invalida = inv_q;
  assign botao_ativo     = ativo_q;
  assign db_estado       = estado_q;

endmodule

// File: tb/tb_condicionador_botoes.sv
// Scoreboard bench for condicionador_botoes: press transactions predict pulse cycles, a monitor matches them.
module tb_condicionador_botoes;
  localparam int D = 20;
  localparam int L = 2000;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] botoes;
  logic [3:0] jogada;
  logic       tem_jogada, jogada_invalida, pressao_longa, botao_ativo;
  logic [1:0] db_estado;

  condicionador_botoes #(.DEBOUNCE_CICLOS(D), .LONGO_CICLOS(L)) dut (
    .clock(clock), .reset(reset), .botoes(botoes), .jogada(jogada),
    .tem_jogada(tem_jogada), .jogada_invalida(jogada_invalida),
    .pressao_longa(pressao_longa), .botao_ativo(botao_ativo), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int         t;
    int         kind;   // 0 tem_jogada, 1 jogada_invalida, 2 pressao_longa
    logic [3:0] val;
  } ev_t;

  ev_t        sbq[$];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] mon_jog = 4'b0;

  // Monitor: pops expected events when a pulse appears, flags missed ones.
  always @(negedge clock) begin
    logic [2:0] p;
    ev_t        e;
    if (reset) begin
      mon_jog = 4'b0;
    end else begin
      while (sbq.size() > 0 && sbq[0].t < cyc) begin
        checks++; errors++;
        $display("FAIL missed_event got no pulse required kind=%0d at t=%0d (now %0d)",
                 sbq[0].kind, sbq[0].t, cyc);
        void'(sbq.pop_front());
      end
      p = {pressao_longa, jogada_invalida, tem_jogada};
      for (int k = 0; k < 3; k++) begin
        if (p[k]) begin
          checks++;
          if (sbq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse got kind=%0d at t=%0d required none", k, cyc);
          end else begin
            e = sbq.pop_front();
            if (e.kind != k || e.t != cyc || (k == 0 && jogada !== e.val)) begin
              errors++;
              $display("FAIL event got kind=%0d t=%0d jogada=%b required kind=%0d t=%0d jogada=%b",
                       k, cyc, jogada, e.kind, e.t, e.val);
            end
            if (e.kind == 0) mon_jog = e.val;
          end
        end
      end
      checks++;
      if (jogada !== mon_jog) begin
        errors++;
        $display("FAIL jogada_hold got %b required %b at t=%0d", jogada, mon_jog, cyc);
      end
    end
  end

  function automatic bit is_onehot(input logic [3:0] v);
    int n = 0;
    for (int i = 0; i < 4; i++) if (v[i]) n++;
    return n == 1;
  endfunction

  task automatic push_ev(input int t, input int kind, input logic [3:0] v);
    ev_t e;
    e.t = t; e.kind = kind; e.val = v;
    sbq.push_back(e);
  endtask

  // A vector stable from cycle n0 long enough is reported D+4 cycles later.
  task automatic expect_press(input logic [3:0] v, input int n0, input int hold);
    if (hold >= D + 5) begin
      if (is_onehot(v)) begin
        push_ev(n0 + D + 4, 0, v);
`ifdef BOTAO_LONGO_EN
        if (hold >= D + L + 10) push_ev(n0 + D + 4 + L, 2, v);
`endif
      end else begin
        push_ev(n0 + D + 4, 1, v);
      end
    end
  endtask

  task automatic set_b(input logic [3:0] v, input int n);
    botoes = v;
    repeat (n) @(negedge clock);
  endtask

  task automatic check_idle(input string nome);
    checks++;
    if (sbq.size() != 0 || db_estado !== 2'd0 || botao_ativo !== 1'b0) begin
      errors++;
      $display("FAIL %s got pending=%0d db_estado=%0d botao_ativo=%b required 0 0 0",
               nome, sbq.size(), db_estado, botao_ativo);
    end
  endtask

  task automatic press(input logic [3:0] v, input int hold, input int nb, input int nrel);
    int n0;
    for (int i = 0; i < nb; i++) begin
      set_b(4'($urandom_range(1, 15)), int'($urandom_range(1, 8)));
      set_b(4'b0, int'($urandom_range(1, 3)));
    end
    botoes = v;
    n0 = cyc;
    expect_press(v, n0, hold);
    repeat (hold) @(negedge clock);
    for (int i = 0; i < nrel; i++) begin
      set_b(4'b0, int'($urandom_range(1, 3)));
      set_b(4'($urandom_range(1, 15)), int'($urandom_range(1, 4)));
    end
    set_b(4'b0, D + 10);
    check_idle("idle_after_press");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at t=%0d", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    reset  = 1'b1;
    botoes = 4'b0;
    repeat (3) @(negedge clock);
    checks++;
    if ({jogada, tem_jogada, jogada_invalida, pressao_longa, botao_ativo, db_estado} !== 10'b0) begin
      errors++;
      $display("FAIL reset_state got jogada=%b pulses=%b%b%b ativo=%b estado=%0d required all zero",
               jogada, tem_jogada, jogada_invalida, pressao_longa, botao_ativo, db_estado);
    end
    reset = 1'b0;
    set_b(4'b0, 5);

    press(4'b1000, 10000, 0, 0);

    for (int i = 0; i < 6; i++) begin
      set_b(4'b0100, 5);
      set_b(4'b0000, 5);
    end
    press(4'b0100, 200, 0, 0);

    press(4'b0001, 10, 0, 0);
    press(4'b0011, 100, 0, 0);
    press(4'b0010, 3000, 0, 0);

    // Reset while qualifying a held button.
    botoes = 4'b1000;
    repeat (10) @(negedge clock);
    checks++;
    if (db_estado !== 2'd1 || botao_ativo !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_filtra got estado=%0d ativo=%b required 1 1", db_estado, botao_ativo);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({jogada, tem_jogada, jogada_invalida, pressao_longa, botao_ativo, db_estado} !== 10'b0) begin
      errors++;
      $display("FAIL async_reset got jogada=%b ativo=%b estado=%0d required 0000 0 0",
               jogada, botao_ativo, db_estado);
    end
    repeat (3) @(negedge clock);
    reset = 1'b0;
    n0 = cyc;
    expect_press(4'b1000, n0, 40);
    repeat (40) @(negedge clock);
    set_b(4'b0, D + 10);
    check_idle("idle_after_reset_press");

    for (int i = 0; i < 25; i++) begin
      logic [3:0] v;
      int hold;
      v = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 3) == 0) hold = int'($urandom_range(1, D - 3));
      else                           hold = int'($urandom_range(D + 5, D + 150));
      press(v, hold, int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
    end

    repeat (5) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/condicionador_botoes.md
# condicionador_botoes

Input conditioner that sits directly upstream of `jogo_mindfocus`, between the raw `botoes[3:0]` pins and the game FSM. It synchronizes, debounces and validates the four player buttons. For each physical press it delivers exactly one clean, registered one-hot `jogada` code with a single-cycle `tem_jogada` strobe, no matter how long the button is held. The design clock is 1 kHz (1 ms period), so all cycle counts below are also milliseconds.

## Interface
- `DEBOUNCE_CICLOS`, 20: cycles the button vector must stay constant to be accepted (press and release). Legal range is 2..255.
- `LONGO_CICLOS`, 2000: hold length for long-press detection, counted from the `tem_jogada` cycle. Legal range is greater than `DEBOUNCE_CICLOS` and at most 65535.

Ports (clock and reset first):
- `clock` in 1: single system clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `botoes` in 4: raw asynchronous button levels, 1 = pressed.
- `jogada` out 4: last accepted one-hot button code; holds its value until the next valid press.
- `tem_jogada` out 1: one-cycle pulse when `jogada` is updated.
- `jogada_invalida` out 1: one-cycle pulse when a stable press has zero or more than one bit set.
- `pressao_longa` out 1: one-cycle long-press pulse (only when `BOTAO_LONGO_EN` is defined).
- `botao_ativo` out 1: high in FILTRA, REGISTRA and SOLTA.
- `db_estado` out 2: current FSM state code.

## Operation
- Two-flop synchronizer per bit gives `b_sync[3:0]`. FSM and counters observe only `b_sync`.
- `amostra[3:0]` register holds the vector being qualified.
- `cont` is a saturating counter, width `$clog2(LONGO_CICLOS+1)`.
- FSM states:
  - ESPERA (0):
    - If `b_sync != 0`: load `amostra <= b_sync`, `cont <= 0`, go to FILTRA.
  - FILTRA (1):
    - If `b_sync == 0`: go to ESPERA with no output.
    - Else if `b_sync != amostra`: reload `amostra`, `cont <= 0`.
    - Else if `cont == DEBOUNCE_CICLOS-1`: go to REGISTRA.
    - Else `cont++`.
  - REGISTRA (2), one cycle:
    - If `amostra` is one-hot: `jogada <= amostra`, `tem_jogada <= 1`.
    - Otherwise: `jogada_invalida <= 1` and `jogada` is unchanged.
    - Then `cont <= 0`, go to SOLTA.
  - SOLTA (3): waits for a debounced release.
    - If `b_sync == 0`: `cont++`. When `cont == DEBOUNCE_CICLOS-1`, go to ESPERA.
    - Any nonzero `b_sync` resets `cont` to 0, so bounce on release is absorbed.
    - A different button pressed before release is complete produces no new `jogada`. Release plus re-press is mandatory.
- All outputs are registered. Pulse outputs are high for exactly one cycle.
- Reset values: `jogada=0000`, all pulses 0, `botao_ativo=0`, `db_estado=0`, sync flops 0, `amostra=0000`, `cont=0`.

## Timing
- Let E0 be the first rising edge at which a stable nonzero `botoes` is captured in sync stage 1. Then:
  - FSM enters FILTRA at E2.
  - REGISTRA is entered at E0+`DEBOUNCE_CICLOS`+2.
  - `tem_jogada` / `jogada_invalida` are high in the cycle following that edge, i.e. the pulse is registered at E0+`DEBOUNCE_CICLOS`+3.
  - `jogada` changes on the same edge as `tem_jogada` rises.
- Any change of `b_sync` during FILTRA restarts the full `DEBOUNCE_CICLOS` window.
- Minimum press-to-press spacing is about 2·`DEBOUNCE_CICLOS`+5 cycles.
- Simultaneous presses landing in the same sync sample form one multi-bit vector and yield `jogada_invalida`.
- Reset mid-operation clears everything immediately. A button still held at reset release is re-qualified from ESPERA and produces one fresh `tem_jogada`.

## Configuration
- Macro `BOTAO_LONGO_EN`.
- Defined:
  - In SOLTA after a valid REGISTRA, a second counter counts cycles while `b_sync == amostra`.
  - At count `LONGO_CICLOS-1` it pulses `pressao_longa` once per press.
  - Any deviation of `b_sync` stops the count for the rest of that press.
- Undefined: the counter is not built and `pressao_longa` is tied to 0.

## Test plan
- Reset, then `botoes=1000` held 10000 cycles → exactly one `tem_jogada` at E0+23 (default parameters), `jogada=1000`, no further pulses. On release, `db_estado` returns to 0 about 22 cycles later.
- `botoes` toggles 0100/0000 every 5 cycles for 60 cycles, then holds 0100 → exactly one `tem_jogada`, 23 cycles after the last toggle, `jogada=0100`.
- 10-cycle glitch of 0001, shorter than `DEBOUNCE_CICLOS` → no pulse, `jogada` unchanged, `db_estado` back to 0.
- `botoes=0011` stable for 100 cycles → one `jogada_invalida` pulse, `tem_jogada` stays 0, `jogada` keeps its previous value.
- `BOTAO_LONGO_EN` defined, 0010 held 3000 cycles → `tem_jogada`, then one `pressao_longa` 2000 cycles later. With the macro undefined, `pressao_longa` stays 0 throughout.
- `reset` pulsed while in FILTRA with 1000 held → outputs return to reset values asynchronously. After reset release, one `tem_jogada` with `jogada=1000`.
